cmd_match_fifo: RTL and testbench

Parametrised UART command matcher: compares a received byte stream against a compile-time table of NUM_KW keywords and queues one ASCII result code per match or per unmatched line. Results go through an internal FIFO with a ready/valid output, so the downstream UART transmitter can stall without losing codes. Sits between the UART receiver (`valid`/`recv_data`) and `uart_send`.

---
 rtl/cmd_match_fifo.sv | 152 +++++++++++++++
 tb/tb_cmd_match_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_match_fifo.sv
// Keyword matcher for a UART byte stream that queues one ASCII result code per hit or unmatched line.
// Define CASE_FOLD_EN to fold uppercase data bytes to lowercase before comparison.
module cmd_match_fifo #(
    parameter int                          NUM_KW     = 3,
    parameter int                          MAX_LEN    = 5,
    // Byte 0 of each keyword sits in the low bits, hence the reversed literals.
    parameter logic [NUM_KW*MAX_LEN*8-1:0] KW_TABLE   = {"zstih", 8'h00, "pots", "trats"},
    parameter logic [NUM_KW*4-1:0]         KW_LEN     = {4'd5, 4'd4, 4'd5},
    parameter int                          MODE       = 0,
    parameter int                          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] recv_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] drop_cnt
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic       r_in_valid;
    logic [7:0] r_in_byte;
    logic [3:0] r_pos [NUM_KW];
    logic       r_line_nonempty;
    logic       r_line_hit;
    logic [3:0] r_last_hit;
    logic [7:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0] r_drop_cnt;

    logic       w_is_term;
    logic       w_term;
    logic       w_data;
    logic [7:0] w_byte;
    logic [3:0] w_cand [NUM_KW];
    logic [3:0] w_pos_next [NUM_KW];
    logic [NUM_KW-1:0] w_hit_vec;
    logic       w_hit_any;
    logic [3:0] w_hit_idx;
    logic       w_push;
    logic [7:0] w_push_code;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_wr;
    logic       w_drop;

    function automatic logic [7:0] kw_byte(input int k, input logic [3:0] j);
        kw_byte = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (j == i[3:0]) kw_byte = KW_TABLE[(k*MAX_LEN+i)*8 +: 8];
        end
    endfunction

    assign w_is_term = (r_in_byte == 8'h0D) || (r_in_byte == 8'h0A);
    assign w_term    = r_in_valid && w_is_term;
    assign w_data    = r_in_valid && !w_is_term;

`ifdef CASE_FOLD_EN
    assign w_byte = ((r_in_byte >= 8'h41) && (r_in_byte <= 8'h5A)) ? (r_in_byte + 8'h20) : r_in_byte;
`else
    assign w_byte = r_in_byte;
`endif

    always_comb begin
        w_hit_vec = '0;
        for (int k = 0; k < NUM_KW; k++) begin
            w_cand[k] = 4'd0;
            if (w_byte == kw_byte(k, r_pos[k])) w_cand[k] = r_pos[k] + 4'd1;
            else if (w_byte == KW_TABLE[k*MAX_LEN*8 +: 8]) w_cand[k] = 4'd1;
            w_hit_vec[k]  = w_data && (w_cand[k] == KW_LEN[k*4 +: 4]);
            w_pos_next[k] = w_hit_vec[k] ? 4'd0 : w_cand[k];
        end
    end

    // Descending scan so the lowest-index hit wins.
    always_comb begin
        w_hit_idx = 4'd0;
        for (int k = NUM_KW - 1; k >= 0; k--) begin
            if (w_hit_vec[k]) w_hit_idx = k[3:0];
        end
    end
    assign w_hit_any = |w_hit_vec;

    always_comb begin
        w_push      = 1'b0;
        w_push_code = 8'h30;
        if (MODE == 0) begin
            if (w_hit_any) begin
                w_push      = 1'b1;
                w_push_code = 8'h31 + {4'h0, w_hit_idx};
            end else if (w_term && r_line_nonempty && !r_line_hit) begin
                w_push = 1'b1;
            end
        end else begin
            if (w_term && r_line_nonempty) begin
                w_push = 1'b1;
                if (r_line_hit) w_push_code = 8'h31 + {4'h0, r_last_hit};
            end
        end
    end

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop    = tx_valid && tx_ready;
    assign w_wr     = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign tx_valid = !w_empty;
    assign tx_data  = r_mem[r_rptr[AW-1:0]];
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid      <= 1'b0;
            r_in_byte       <= 8'h00;
            r_line_nonempty <= 1'b0;
            r_line_hit      <= 1'b0;
            r_last_hit      <= 4'd0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_drop_cnt      <= 8'h00;
            for (int k = 0; k < NUM_KW; k++) r_pos[k] <= 4'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_in_valid <= valid;
            r_in_byte  <= recv_data;
            if (w_term) begin
                r_line_nonempty <= 1'b0;
                r_line_hit      <= 1'b0;
                r_last_hit      <= 4'd0;
                for (int k = 0; k < NUM_KW; k++) r_pos[k] <= 4'd0;
            end else if (w_data) begin
                r_line_nonempty <= 1'b1;
                for (int k = 0; k < NUM_KW; k++) r_pos[k] <= w_pos_next[k];
                if (w_hit_any) begin
                    r_line_hit <= 1'b1;
                    r_last_hit <= w_hit_idx;
                end
            end
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= w_push_code;
                r_wptr                <= r_wptr + PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end
endmodule

// File: tb/tb_cmd_match_fifo.sv
// Directed bench: one MODE 0 and one MODE 1 matcher fed the same byte stream, popped codes collected per instance.
module tb_cmd_match_fifo;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] recv_data = 8'h00;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data0, tx_data1, drop_cnt0, drop_cnt1;
    logic       tx_valid0, tx_valid1;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    string exp_upper;

    always #5 clk = ~clk;

    cmd_match_fifo #(.MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .valid(valid), .recv_data(recv_data),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready), .drop_cnt(drop_cnt0)
    );

    cmd_match_fifo #(.MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .valid(valid), .recv_data(recv_data),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready), .drop_cnt(drop_cnt1)
    );

    // A code seen here with tx_ready high is popped at the following rising edge.
    always @(negedge clk) begin
        if (tx_valid0 && tx_ready) q0.push_back(tx_data0);
        if (tx_valid1 && tx_ready) q1.push_back(tx_data1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        valid     = 1'b1;
        recv_data = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stream(input string tag, input int which, input string exp);
        int         sz;
        logic [7:0] got;
        sz = (which == 0) ? q0.size() : q1.size();
        check($sformatf("%s_len", tag), sz, exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            got = 8'hFF;
            if (i < sz) got = (which == 0) ? q0[i] : q1[i];
            check($sformatf("%s_code%0d", tag, i), got, exp[i]);
        end
        if (which == 0) q0.delete();
        else q1.delete();
    endtask

    initial begin
`ifdef CASE_FOLD_EN
        exp_upper = "3";
`else
        exp_upper = "0";
`endif
        rst = 1'b1;
        idle(3);
        check("rst_valid0", tx_valid0, 1'b0);
        check("rst_valid1", tx_valid1, 1'b0);
        check("rst_data0", tx_data0, 8'h00);
        check("rst_drop0", drop_cnt0, 8'h00);
        rst = 1'b0;
        tx_ready = 1'b1;
        idle(2);

        // Latency: code appears one cycle after the final 't' is taken.
        send_str("star");
        send_byte("t");
        @(negedge clk);
        check("start_early_valid", tx_valid0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("start_lat_valid", tx_valid0, 1'b1);
        check("start_lat_data", tx_data0, 8'h31);
        send_byte(CR);
        idle(4);
        check_stream("start_m0", 0, "1");
        check_stream("start_m1", 1, "1");

        send_str("xyz");
        send_byte(CR);
        send_byte(LF);
        idle(4);
        check_stream("xyz_m0", 0, "0");
        check_stream("xyz_m1", 1, "0");

        send_str("sstop hhitsz");
        send_byte(LF);
        idle(5);
        check_stream("overlap_m0", 0, "23");
        check_stream("overlap_m1", 1, "3");

        send_str("stop start");
        send_byte(CR);
        idle(5);
        check_stream("two_m0", 0, "21");
        check_stream("two_m1", 1, "1");

        send_str("hitsz");
        send_byte(CR);
        idle(4);
        check_stream("lower_m0", 0, "3");
        check_stream("lower_m1", 1, "3");

        send_str("HITSZ");
        send_byte(CR);
        idle(4);
        check_stream("upper_m0", 0, exp_upper);
        check_stream("upper_m1", 1, exp_upper);

        send_byte(CR);
        send_byte(LF);
        send_byte(LF);
        idle(4);
        check_stream("empty_m0", 0, "");
        check_stream("empty_m1", 1, "");

        // Fill with the consumer stalled: four kept, two dropped.
        tx_ready = 1'b0;
        repeat (6) begin
            send_byte("a");
            send_byte(LF);
        end
        idle(3);
        check("full_valid0", tx_valid0, 1'b1);
        check("full_data0", tx_data0, 8'h30);
        check("full_drop0", drop_cnt0, 8'd2);
        check("full_drop1", drop_cnt1, 8'd2);

        // Push lands on the same edge as the first pop of a full FIFO.
        send_byte("a");
        send_byte(LF);
        tx_ready = 1'b1;
        idle(8);
        check("pushpop_drop0", drop_cnt0, 8'd2);
        check("pushpop_drop1", drop_cnt1, 8'd2);
        check("drained_valid0", tx_valid0, 1'b0);
        check_stream("drain_m0", 0, "00000");
        check_stream("drain_m1", 1, "00000");

        tx_ready = 1'b0;
        repeat (300) begin
            send_byte("a");
            send_byte(LF);
        end
        idle(3);
        check("sat_drop0", drop_cnt0, 8'd255);
        check("sat_drop1", drop_cnt1, 8'd255);
        tx_ready = 1'b1;
        idle(8);
        check("sat_drained_valid1", tx_valid1, 1'b0);
        q0.delete();
        q1.delete();

        // Reset mid-line with codes queued.
        tx_ready = 1'b0;
        send_byte("a");
        send_byte(LF);
        send_byte("b");
        send_byte(LF);
        idle(3);
        check("preq_valid0", tx_valid0, 1'b1);
        send_str("sta");
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_valid0", tx_valid0, 1'b0);
        check("postrst_valid1", tx_valid1, 1'b0);
        check("postrst_data0", tx_data0, 8'h00);
        check("postrst_drop0", drop_cnt0, 8'h00);
        check("postrst_drop1", drop_cnt1, 8'h00);
        @(posedge clk);
        #1;
        check("postrst_next_valid0", tx_valid0, 1'b0);
        tx_ready = 1'b1;
        send_str("rt");
        send_byte(LF);
        idle(5);
        check_stream("rstline_m0", 0, "0");
        check_stream("rstline_m1", 1, "0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
